// File: rtl/dma_desc_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dma_desc_writer_if                                                |
// | Brief    : Descriptor FIFO, data FIFO, memory write and completion signals   |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface dma_desc_writer_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic                    desc_empty;
  logic [LEN_W+ADDR_W-1:0] desc_dout;
  logic                    desc_rd_en;
  logic                    data_empty;
  logic [31:0]             data_dout;
  logic                    data_rd_en;
  logic                    o_mem_wren;
  logic [ADDR_W-1:0]       o_mem_addr;
  logic [31:0]             o_mem_wdata;
  logic [3:0]              o_mem_wstrb;
  logic                    i_mem_ready;
  logic                    o_done_valid;
  logic [LEN_W-1:0]        o_done_len;
  logic                    o_done_err;
  logic [15:0]             o_desc_cnt;

  modport master (
    input  desc_empty, desc_dout, data_empty, data_dout, i_mem_ready,
    output desc_rd_en, data_rd_en, o_mem_wren, o_mem_addr, o_mem_wdata,
           o_mem_wstrb, o_done_valid, o_done_len, o_done_err, o_desc_cnt
  );

  modport slave (
    output desc_empty, desc_dout, data_empty, data_dout, i_mem_ready,
    input  desc_rd_en, data_rd_en, o_mem_wren, o_mem_addr, o_mem_wdata,
           o_mem_wstrb, o_done_valid, o_done_len, o_done_err, o_desc_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dma_desc_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dma_desc_writer                                                   |
// | Brief    : Pops a {len, addr} descriptor, streams its data words to memory   |
// |            and reports one completion record per descriptor                  |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module dma_desc_writer #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  wire logic          clk,
  input  wire logic          srst,
  dma_desc_writer_if.master  bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_LOAD  = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;
  localparam int         c_TCNT_W   = $clog2(TIMEOUT + 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_words_left;
  logic [LEN_W-1:0]    r_acc;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_wren;
  logic [c_TCNT_W-1:0] r_tcnt;
  logic                r_tmo;
  logic [15:0]         r_desc_cnt;

  logic                w_desc_pop;
  logic                w_slot_free;
  logic                w_accept;
  logic                w_pop;
  logic                w_starve;
  logic                w_tmo_hit;
  logic [LEN_W:0]      w_len_p3;
  logic [LEN_W-1:0]    w_words;
  logic [3:0]          w_last_strb;
  logic [LEN_W+1:0]    w_bytes;

  assign w_desc_pop  = (r_state == c_ST_IDLE) && !bus.desc_empty && !srst;
  assign w_slot_free = !r_wren || bus.i_mem_ready;
  assign w_accept    = r_wren && bus.i_mem_ready;
  assign w_pop       = (r_state == c_ST_WRITE) && w_slot_free && (r_words_left != '0)
                       && !bus.data_empty && !r_tmo;
  assign w_starve    = (r_state == c_ST_WRITE) && (r_words_left != '0)
                       && bus.data_empty && !r_tmo;
  assign w_tmo_hit   = w_starve && (r_tcnt == c_TCNT_W'(TIMEOUT - 1));
  assign w_len_p3    = {1'b0, r_len} + (LEN_W+1)'(3);
  assign w_words     = LEN_W'(w_len_p3 >> 2);
  assign w_bytes     = {r_acc, 2'b00};

  always_comb begin
    case (r_len[1:0])
      2'd1:    w_last_strb = 4'h1;
      2'd2:    w_last_strb = 4'h3;
      2'd3:    w_last_strb = 4'h7;
      default: w_last_strb = 4'hF;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) r_state <= c_ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_desc_pop) w_next = c_ST_LOAD;
      c_ST_LOAD:  w_next = (r_len == '0) ? c_ST_DONE : c_ST_WRITE;
      // A pending write always drains before the descriptor is closed.
      c_ST_WRITE: if (w_slot_free && !w_pop &&
                      ((r_words_left == '0) || r_tmo || w_tmo_hit))
                    w_next = c_ST_DONE;
      default:    w_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    bus.desc_rd_en   = w_desc_pop;
    bus.data_rd_en   = w_pop;
    bus.o_done_valid = 1'b0;
    bus.o_done_len   = '0;
    bus.o_done_err   = 1'b0;
    if (r_state == c_ST_DONE) begin
      bus.o_done_valid = 1'b1;
      bus.o_done_len   = (w_bytes > {2'b00, r_len}) ? r_len : w_bytes[LEN_W-1:0];
      bus.o_done_err   = r_tmo;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_words_left <= '0;
      r_acc        <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_wren       <= 1'b0;
      r_tcnt       <= '0;
      r_tmo        <= 1'b0;
      r_desc_cnt   <= '0;
    end else begin
      if (w_desc_pop) begin
        r_len  <= bus.desc_dout[ADDR_W +: LEN_W];
        r_addr <= bus.desc_dout[ADDR_W-1:0] & ~ADDR_W'(3);
      end
      if (r_state == c_ST_LOAD) begin
        r_words_left <= w_words;
        r_acc        <= '0;
        r_tcnt       <= '0;
        r_tmo        <= 1'b0;
      end
      if (w_accept) begin
        r_addr <= r_addr + ADDR_W'(4);
        r_acc  <= r_acc + LEN_W'(1);
      end
      if (w_pop) begin
        r_wdata      <= bus.data_dout;
        r_wstrb      <= (r_words_left == LEN_W'(1)) ? w_last_strb : 4'hF;
        r_words_left <= r_words_left - LEN_W'(1);
        r_wren       <= 1'b1;
        r_tcnt       <= '0;
      end else if (w_accept) begin
        r_wren <= 1'b0;
      end
      if (w_starve) r_tcnt <= r_tcnt + c_TCNT_W'(1);
      if (w_tmo_hit) r_tmo <= 1'b1;
      // Count moves together with the completion pulse.
      if ((r_state != c_ST_DONE) && (w_next == c_ST_DONE))
        r_desc_cnt <= r_desc_cnt + 16'd1;
    end
  end

  assign bus.o_mem_wren  = r_wren;
  assign bus.o_mem_addr  = r_addr;
  assign bus.o_mem_wdata = r_wdata;
  assign bus.o_mem_wstrb = r_wstrb;
  assign bus.o_desc_cnt  = r_desc_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dma_desc_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dma_desc_writer                                                |
// | Brief    : Directed vector bench with show-ahead FIFO and memory models      |
// | Revision : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_dma_desc_writer;

  typedef struct {
    logic [15:0] len;
    logic [31:0] addr;
    int          ndata;
    bit          toggle;
    logic [31:0] base;
    int          exp_nwr;
    logic [3:0]  exp_last;
    logic [15:0] exp_dlen;
    bit          exp_err;
    int          exp_left;
    int          exp_gap;
  } vec_t;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  dma_desc_writer_if #(.ADDR_W(32), .LEN_W(16)) bus ();
  dma_desc_writer #(.ADDR_W(32), .LEN_W(16), .TIMEOUT(4)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  logic [47:0] dq[$];
  logic [31:0] wq[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  ws[$];
  vec_t        vt[7];

  int errors = 0, checks = 0;
  int cyc = 0, ndone = 0, done_cyc = 0, pop_cyc = 0, viol = 0, hold_err = 0;
  bit tog = 1'b0;
  logic [15:0] d_len, d_cnt;
  logic        d_err;
  logic        p_stall;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_strb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_heads();
    bus.desc_empty = (dq.size() == 0);
    bus.desc_dout  = (dq.size() == 0) ? 48'h0 : dq[0];
    bus.data_empty = (wq.size() == 0);
    bus.data_dout  = (wq.size() == 0) ? 32'h0 : wq[0];
  endtask

  task automatic step();
    logic pd, pw;
    @(negedge clk);
    cyc++;
    if (bus.desc_rd_en && bus.desc_empty) viol++;
    if (bus.data_rd_en && bus.data_empty) viol++;
    if (p_stall && !(bus.o_mem_wren && bus.o_mem_addr == p_addr &&
                     bus.o_mem_wdata == p_data && bus.o_mem_wstrb == p_strb)) hold_err++;
    p_stall = bus.o_mem_wren && !bus.i_mem_ready && !srst;
    p_addr  = bus.o_mem_addr;
    p_data  = bus.o_mem_wdata;
    p_strb  = bus.o_mem_wstrb;
    if (bus.o_mem_wren && bus.i_mem_ready) begin
      wa.push_back(bus.o_mem_addr);
      wd.push_back(bus.o_mem_wdata);
      ws.push_back(bus.o_mem_wstrb);
    end
    if (bus.o_done_valid) begin
      ndone++;
      done_cyc = cyc;
      d_len = bus.o_done_len;
      d_err = bus.o_done_err;
      d_cnt = bus.o_desc_cnt;
    end
    pd = bus.desc_rd_en;
    pw = bus.data_rd_en;
    if (pw) pop_cyc = cyc;
    @(posedge clk);
    #1;
    if (pd && dq.size() > 0) void'(dq.pop_front());
    if (pw && wq.size() > 0) void'(wq.pop_front());
    bus.i_mem_ready = tog ? ~bus.i_mem_ready : 1'b1;
    set_heads();
  endtask

  task automatic clear_logs();
    wa.delete(); wd.delete(); ws.delete();
    ndone = 0; hold_err = 0;
  endtask

  initial begin
    //        len     addr          nd tog base      nwr last  dlen    err left gap
    vt[0] = '{16'd8,  32'h0000_1000, 2, 1'b0, 32'hA,  2, 4'hF, 16'd8,  1'b0, 0, 0};
    vt[1] = '{16'd5,  32'h0000_2003, 2, 1'b0, 32'h20, 2, 4'h1, 16'd5,  1'b0, 0, 0};
    vt[2] = '{16'd0,  32'h0000_3000, 1, 1'b0, 32'h30, 0, 4'hF, 16'd0,  1'b0, 1, 0};
    vt[3] = '{16'd16, 32'h0000_4000, 4, 1'b1, 32'h40, 4, 4'hF, 16'd16, 1'b0, 0, 0};
    vt[4] = '{16'd12, 32'h0000_5000, 1, 1'b0, 32'h50, 1, 4'hF, 16'd4,  1'b1, 0, 5};
    vt[5] = '{16'd7,  32'h0000_6002, 3, 1'b0, 32'h60, 2, 4'h7, 16'd7,  1'b0, 1, 0};
    vt[6] = '{16'd3,  32'h0000_7001, 1, 1'b1, 32'h70, 1, 4'h7, 16'd3,  1'b0, 0, 0};

    srst = 1'b1;
    bus.i_mem_ready = 1'b1;
    p_stall = 1'b0;
    set_heads();
    repeat (2) step();
    @(negedge clk);
    chk("rst_wren",  {63'h0, bus.o_mem_wren}, 64'h0);
    chk("rst_addr",  {32'h0, bus.o_mem_addr}, 64'h0);
    chk("rst_wdata", {32'h0, bus.o_mem_wdata}, 64'h0);
    chk("rst_done",  {63'h0, bus.o_done_valid}, 64'h0);
    chk("rst_cnt",   {48'h0, bus.o_desc_cnt}, 64'h0);
    @(posedge clk); #1;
    srst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      clear_logs();
      tog = vt[v].toggle;
      bus.i_mem_ready = 1'b1;
      dq.push_back({vt[v].len, vt[v].addr});
      for (int i = 0; i < vt[v].ndata; i++) wq.push_back(vt[v].base + 32'(i));
      set_heads();
      for (int c = 0; c < 60 && ndone == 0; c++) step();
      repeat (3) step();
      chk($sformatf("v%0d_nwr", v), 64'(wa.size()), 64'(vt[v].exp_nwr));
      for (int i = 0; i < vt[v].exp_nwr && i < wa.size(); i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), {32'h0, wa[i]},
            {32'h0, (vt[v].addr & 32'hFFFF_FFFC) + 32'(4 * i)});
        chk($sformatf("v%0d_data%0d", v, i), {32'h0, wd[i]}, {32'h0, vt[v].base + 32'(i)});
        chk($sformatf("v%0d_strb%0d", v, i), {60'h0, ws[i]},
            {60'h0, (i == vt[v].exp_nwr - 1) ? vt[v].exp_last : 4'hF});
      end
      chk($sformatf("v%0d_ndone", v), 64'(ndone), 64'd1);
      chk($sformatf("v%0d_dlen", v), {48'h0, d_len}, {48'h0, vt[v].exp_dlen});
      chk($sformatf("v%0d_err", v), {63'h0, d_err}, {63'h0, vt[v].exp_err});
      chk($sformatf("v%0d_cnt", v), {48'h0, d_cnt}, 64'(v + 1));
      chk($sformatf("v%0d_left", v), 64'(wq.size()), 64'(vt[v].exp_left));
      chk($sformatf("v%0d_hold", v), 64'(hold_err), 64'd0);
      if (vt[v].exp_gap != 0)
        chk($sformatf("v%0d_gap", v), 64'(done_cyc - pop_cyc), 64'(vt[v].exp_gap));
      wq.delete();
      set_heads();
    end

    // Reset in the middle of a 16-byte descriptor, with another one queued.
    clear_logs();
    tog = 1'b0;
    dq.push_back({16'd16, 32'h0000_8000});
    for (int i = 0; i < 4; i++) wq.push_back(32'h80 + 32'(i));
    set_heads();
    for (int c = 0; c < 30 && wa.size() < 2; c++) step();
    chk("mid_nwr", 64'(wa.size()), 64'd2);
    dq.push_back({16'd4, 32'h0000_9000});
    set_heads();
    srst = 1'b1;
    #1;
    chk("mid_wren",  {63'h0, bus.o_mem_wren}, 64'h0);
    chk("mid_addr",  {32'h0, bus.o_mem_addr}, 64'h0);
    chk("mid_wdata", {32'h0, bus.o_mem_wdata}, 64'h0);
    chk("mid_strb",  {60'h0, bus.o_mem_wstrb}, 64'h0);
    chk("mid_drd",   {63'h0, bus.desc_rd_en}, 64'h0);
    chk("mid_wrd",   {63'h0, bus.data_rd_en}, 64'h0);
    chk("mid_cnt",   {48'h0, bus.o_desc_cnt}, 64'h0);
    wq.delete();
    wq.push_back(32'h90);
    set_heads();
    repeat (3) step();
    chk("mid_nodone", 64'(ndone), 64'd0);
    srst = 1'b0;
    clear_logs();
    for (int c = 0; c < 60 && ndone == 0; c++) step();
    repeat (2) step();
    chk("post_nwr", 64'(wa.size()), 64'd1);
    if (wa.size() > 0) begin
      chk("post_addr", {32'h0, wa[0]}, 64'h9000);
      chk("post_data", {32'h0, wd[0]}, 64'h90);
      chk("post_strb", {60'h0, ws[0]}, 64'hF);
    end
    chk("post_ndone", 64'(ndone), 64'd1);
    chk("post_dlen",  {48'h0, d_len}, 64'd4);
    chk("post_err",   {63'h0, d_err}, 64'd0);
    chk("post_cnt",   {48'h0, d_cnt}, 64'd1);
    chk("rd_while_empty", 64'(viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
